chunked_adder_ctrl: RTL and testbench



---
 rtl/chunked_adder_pkg.sv | 23 ++
 rtl/chunked_adder_ctrl_slice.sv | 55 +++++
 rtl/chunked_adder_ctrl.sv | 140 ++++++++++++++
 tb/tb_chunked_adder_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the chunked multi-cycle adder.
// The controller and its ripple slice both import this package.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic int num_chunks(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  // The chunk index counter is always at least one bit wide, even for a single chunk.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_adder_ctrl_slice.sv
// CHUNK-bit combinational ripple adder built from per-bit odd-parity (sum)
// and majority (carry) cells; shared by every chunk of the wide add.
module odd3_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic o
);
  assign o = x ^ y ^ z;
endmodule

module maj3_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic o
);
  assign o = (x & y) | (x & z) | (y & z);
endmodule

module adder_slice
  import chunked_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  // The critical path is one majority cell per bit followed by the final parity cell.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    odd3_cell u_sum (
      .x(a[i]),
      .y(b[i]),
      .z(c[i]),
      .o(s[i])
    );
    maj3_cell u_carry (
      .x(a[i]),
      .y(b[i]),
      .z(c[i]),
      .o(c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared CHUNK-bit slice processes a chunk per
// clock, with the carry held in a register between chunks.
module chunked_adder_ctrl
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_adder_ctrl: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  state_t           state;
  state_t           next_state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [WIDTH:0]   sum_reg;
  logic [WIDTH:0]   sum_next;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             accept;
  logic             last_chunk;

  // A new request is taken in IDLE, and also in DONE so operations can run back-to-back.
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_chunk = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ADD;
        end
      end
      ADD: begin
        if (last_chunk) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = start ? ADD : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  // Operand chunk select feeding the shared slice.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        a_chunk = a_reg[k*CHUNK +: CHUNK];
        b_chunk = b_reg[k*CHUNK +: CHUNK];
      end
    end
  end

  adder_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (carry_reg),
    .s   (slice_s),
    .cout(slice_cout)
  );

  // Chunk write mux; the final carry lands in the top bit only on the last chunk.
  always_comb begin
    sum_next = sum_reg;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        sum_next[k*CHUNK +: CHUNK] = slice_s;
      end
    end
    if (last_chunk) begin
      sum_next[WIDTH] = slice_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      idx       <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
      sum_reg   <= '0;
      idx       <= '0;
    end else if (state == ADD) begin
      sum_reg   <= sum_next;
      carry_reg <= slice_cout;
      idx       <= last_chunk ? '0 : (idx + IW'(1));
    end
  end

  assign sum = sum_reg;

endmodule

// File: tb/tb_chunked_adder_ctrl.sv
// Self-checking bench: table-driven vectors and hand-written corner sequences on
// the default 16/4 adder, plus a random sweep on an 8/2 instance.
module tb_chunked_adder_ctrl;

  localparam int NRAND = 1000;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [16:0] sum;

  logic        s8_start;
  logic [7:0]  s8_a;
  logic [7:0]  s8_b;
  logic        s8_cin;
  logic        s8_busy;
  logic        s8_done;
  logic [8:0]  s8_sum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] exp_q[$];
  logic [8:0]  exp8_q[$];
  vec_t        tbl[8];

  always #125 clk = ~clk;

  chunked_adder_ctrl #(.WIDTH(16), .CHUNK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum)
  );

  chunked_adder_ctrl #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(s8_start),
    .a    (s8_a),
    .b    (s8_b),
    .cin  (s8_cin),
    .busy (s8_busy),
    .done (s8_done),
    .sum  (s8_sum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                               input logic tcin, input logic [16:0] texp);
    a     = ta;
    b     = tb;
    cin   = tcin;
    start = 1'b1;
    exp_q.push_back(texp);
  endtask

  // Called at a falling edge once the DUT is in ADD; returns cycles to done.
  task automatic waitDone(output int lat, output int busyc);
    lat   = 0;
    busyc = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busyc++;
    end
  endtask

  task automatic checkOutput(input string name, input int exp_lat, input int lat, input int busyc);
    logic [16:0] e;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busyc), 32'(exp_lat));
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " busy at done"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s scoreboard: got an output, expected none pending", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " sum"}, 32'(sum), 32'(e));
    end
  endtask

  initial begin
    int lat;
    int busyc;
    int ndone;
    logic [8:0] e8;

    tbl[0] = '{16'h1234, 16'h4321, 1'b1, 17'h05556};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    tbl[5] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
    tbl[7] = '{16'hAAAA, 16'h5555, 1'b1, 17'h10000};

    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    s8_start = 1'b0;
    s8_a     = '0;
    s8_b     = '0;
    s8_cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset sum8", 32'(s8_sum), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = ~a;
      cin   = ~cin;
      waitDone(lat, busyc);
      checkOutput($sformatf("vec%0d", i), 4, lat, busyc);
      @(negedge clk);
      check($sformatf("vec%0d idle done", i), 32'(done), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("idle sum hold", 32'(sum), 32'(tbl[7].exp));

    $display("[TB] reset mid-add, carry ripple operands");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst1 busy", 32'(busy), 32'd0);
    check("rst1 done", 32'(done), 32'd0);
    check("rst1 sum", 32'(sum), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst1 no done", 32'(ndone), 32'd0);

    $display("[TB] reset mid-add, partial sum");
    applyStimulus(16'h1234, 16'h4321, 1'b1, 17'h05556);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst2 partial sum", 32'(sum), 32'h00056);
    rst = 1'b1;
    #1;
    check("rst2 busy", 32'(busy), 32'd0);
    check("rst2 sum", 32'(sum), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] start ignored while busy");
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 17'h00100);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 16'hAAAA;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, busyc);
    checkOutput("ignore", 2, lat, busyc);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("ignore no second op", 32'(ndone), 32'd0);

    $display("[TB] back-to-back");
    applyStimulus(16'h8000, 16'h8000, 1'b0, 17'h10000);
    @(negedge clk);
    a   = 16'h0003;
    b   = 16'h0004;
    cin = 1'b0;
    exp_q.push_back(17'h00007);
    waitDone(lat, busyc);
    checkOutput("b2b first", 4, lat, busyc);
    @(negedge clk);
    start = 1'b0;
    check("b2b no idle gap", 32'(busy), 32'd1);
    waitDone(lat, busyc);
    checkOutput("b2b second", 4, lat, busyc);
    @(negedge clk);

    $display("[TB] random sweep on 8/2 instance");
    for (int i = 0; i < NRAND; i++) begin
      s8_a     = 8'($urandom);
      s8_b     = 8'($urandom);
      s8_cin   = 1'($urandom);
      s8_start = 1'b1;
      exp8_q.push_back({1'b0, s8_a} + {1'b0, s8_b} + {8'b0, s8_cin});
      @(negedge clk);
      s8_start = 1'b0;
      s8_a     = ~s8_a;
      lat      = 0;
      while (!s8_done && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd4);
      e8 = exp8_q.pop_front();
      check($sformatf("rand%0d sum", i), 32'(s8_sum), 32'(e8));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
